// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss, issues one word read per cycle for the
// whole line and writes the in-order returned words (then the tag) into the cache.
module cache_fill_fsm #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            miss_detected,
    input  logic [ADDR_WIDTH-1:0]           miss_address,
    input  logic                            mem_data_valid,
    input  logic [15:0]                     mem_data,
    output logic                            fsm_busy,
    output logic                            mem_enable,
    output logic                            mem_wr,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic                            write_data_array,
    output logic                            write_tag_array,
    output logic [$clog2(LINE_WORDS)-1:0]   cache_word_offset,
    output logic [15:0]                     cache_data
);

    localparam int unsigned OFF_W      = $clog2(LINE_WORDS);
    localparam int unsigned CNT_W      = OFF_W + 1;
    localparam int unsigned LINE_BYTES = 2 * LINE_WORDS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] base_nxt;
    logic [CNT_W-1:0]      issue_cnt;
    logic [CNT_W-1:0]      issue_nxt;
    logic [CNT_W-1:0]      ret_cnt;
    logic [CNT_W-1:0]      ret_nxt;
    logic                  ret_accept;
    logic                  busy_nxt;
    logic                  mem_enable_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;

    // Next-state, counter and return-strobe decode
    always_comb begin
        state_nxt         = state;
        base_nxt          = base;
        issue_nxt         = issue_cnt;
        ret_nxt           = ret_cnt;
        write_data_array  = 1'b0;
        write_tag_array   = 1'b0;
        cache_word_offset = '0;

        // Returns stop being accepted once the whole line is in, so the tag fires once.
        ret_accept = (state == ISSUE || state == DRAIN) && mem_data_valid
                     && (ret_cnt != CNT_W'(LINE_WORDS));

        if (ret_accept) begin
            write_data_array  = 1'b1;
            cache_word_offset = ret_cnt[OFF_W-1:0];
            ret_nxt           = ret_cnt + CNT_W'(1);
            if (ret_cnt == CNT_W'(LINE_WORDS - 1)) begin
                write_tag_array = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (miss_detected) begin
                    state_nxt = ISSUE;
                    base_nxt  = miss_address & ~ADDR_WIDTH'(LINE_BYTES - 1);
                    issue_nxt = '0;
                    ret_nxt   = '0;
                end
            end
            ISSUE: begin
                issue_nxt = issue_cnt + CNT_W'(1);
                if (issue_cnt == CNT_W'(LINE_WORDS - 1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (ret_nxt == CNT_W'(LINE_WORDS)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        busy_nxt       = (state_nxt != IDLE);
        mem_enable_nxt = (state_nxt == ISSUE);
        mem_addr_nxt   = '0;
        if (state_nxt == ISSUE) begin
            mem_addr_nxt = base_nxt + ADDR_WIDTH'({issue_nxt, 1'b0});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            fsm_busy   <= 1'b0;
            mem_enable <= 1'b0;
            mem_addr   <= '0;
        end else begin
            state      <= state_nxt;
            base       <= base_nxt;
            issue_cnt  <= issue_nxt;
            ret_cnt    <= ret_nxt;
            fsm_busy   <= busy_nxt;
            mem_enable <= mem_enable_nxt;
            mem_addr   <= mem_addr_nxt;
        end
    end

    assign cache_data = mem_data;
    assign mem_wr     = 1'b0;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a pipelined in-order memory model drives returns and
// each fill is checked cycle by cycle against the expected line-fill behaviour.
module tb_cache_fill_fsm;

    localparam int unsigned AW = 16;
    localparam int unsigned LW = 8;
    localparam int unsigned OW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_detected;
    logic [AW-1:0] miss_address;
    logic          mem_data_valid;
    logic [15:0]   mem_data;
    logic          fsm_busy;
    logic          mem_enable;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic          write_data_array;
    logic          write_tag_array;
    logic [OW-1:0] cache_word_offset;
    logic [15:0]   cache_data;

    int errors = 0;
    int checks = 0;
    int tc;

    cache_fill_fsm #(.ADDR_WIDTH(AW), .LINE_WORDS(LW)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .mem_data_valid    (mem_data_valid),
        .mem_data          (mem_data),
        .fsm_busy          (fsm_busy),
        .mem_enable        (mem_enable),
        .mem_wr            (mem_wr),
        .mem_addr          (mem_addr),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .cache_word_offset (cache_word_offset),
        .cache_data        (cache_data)
    );

    always #5 clk = ~clk;

    // One complete fill. Issues occupy cycles 1..LW after acceptance; memory returns
    // word i no earlier than lat cycles after its issue and at least gap+1 cycles
    // after the previous return. Stops early (no further checks) once rst_after
    // returns have been taken, if rst_after > 0.
    task automatic run_fill(input int addr, input int lat, input int gap, input int rst_after,
                            input bit preloaded, input bit keep_miss, input int next_addr,
                            output int tag_cycle);
        int  base;
        int  returned;
        int  last_ret;
        int  pending[$];
        int  exp_addr;
        bit  done;
        bit  finished;
        bit  exp_en;
        bit  v;
        bit  exp_wr;
        bit  exp_tag;
        base      = (addr / (2 * LW)) * (2 * LW);
        returned  = 0;
        last_ret  = -100;
        done      = 1'b0;
        finished  = 1'b0;
        tag_cycle = -1;
        if (!preloaded) begin
            @(negedge clk);
            miss_detected  = 1'b1;
            miss_address   = AW'(addr);
            mem_data_valid = 1'b1;
            mem_data       = 16'($urandom);
            #1;
            checks++;
            if (fsm_busy !== 1'b0 || mem_enable !== 1'b0 || write_data_array !== 1'b0
                || write_tag_array !== 1'b0) begin
                errors++;
                $display("FAIL idle_before_fill: busy=%b en=%b wda=%b tag=%b, all should be 0",
                         fsm_busy, mem_enable, write_data_array, write_tag_array);
            end
        end
        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            if (rst_after > 0 && returned == rst_after) return;
            @(negedge clk);
            if (done) begin
                miss_detected = keep_miss;
                miss_address  = AW'(next_addr);
            end else begin
                miss_detected = 1'($urandom_range(0, 1));
                miss_address  = (cyc % 2 == 1) ? 16'hFFFF : 16'($urandom);
            end
            // In the idle cycle after completion a stray valid must be ignored.
            v = done || (pending.size() > 0 && pending[0] <= cyc && (cyc - last_ret) > gap);
            mem_data_valid = v;
            mem_data       = 16'($urandom);
            if (v && !done) void'(pending.pop_front());
            #1;
            exp_en   = (cyc <= LW);
            exp_addr = exp_en ? base + 2 * (cyc - 1) : 0;
            exp_wr   = v && !done;
            exp_tag  = exp_wr && (returned == LW - 1);
            checks++;
            if (fsm_busy !== !done) begin
                errors++;
                $display("FAIL busy: cycle %0d got %b want %b", cyc, fsm_busy, !done);
            end
            checks++;
            if (mem_enable !== exp_en || mem_addr !== AW'(exp_addr)) begin
                errors++;
                $display("FAIL mem_req: cycle %0d got en=%b addr=%h want en=%b addr=%h",
                         cyc, mem_enable, mem_addr, exp_en, AW'(exp_addr));
            end
            checks++;
            if (write_data_array !== exp_wr || write_tag_array !== exp_tag
                || cache_word_offset !== OW'(exp_wr ? returned : 0)) begin
                errors++;
                $display("FAIL strobes: cycle %0d got wda=%b tag=%b off=%0d want wda=%b tag=%b off=%0d",
                         cyc, write_data_array, write_tag_array, cache_word_offset,
                         exp_wr, exp_tag, exp_wr ? returned : 0);
            end
            checks++;
            if (cache_data !== mem_data || mem_wr !== 1'b0) begin
                errors++;
                $display("FAIL data_path: cycle %0d got data=%h wr=%b want data=%h wr=0",
                         cyc, cache_data, mem_wr, mem_data);
            end
            if (exp_en) pending.push_back(cyc + lat);
            if (exp_wr) begin
                returned++;
                last_ret = cyc;
            end
            if (done) finished = 1'b1;
            if (exp_tag) begin
                done      = 1'b1;
                tag_cycle = cyc;
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL fill_timeout: addr=%h returned=%0d want %0d", addr, returned, LW);
        end
        mem_data_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst            = 1'b1;
        miss_detected  = 1'b1;
        miss_address   = 16'h1234;
        mem_data_valid = 1'b1;
        mem_data       = 16'hA5A5;
        repeat (3) begin
            @(negedge clk);
            #1;
            checks++;
            if (fsm_busy !== 1'b0 || mem_enable !== 1'b0 || mem_addr !== '0
                || write_data_array !== 1'b0 || write_tag_array !== 1'b0 || cache_word_offset !== '0) begin
                errors++;
                $display("FAIL reset_outputs: busy=%b en=%b addr=%h wda=%b tag=%b off=%0d, all should be 0",
                         fsm_busy, mem_enable, mem_addr, write_data_array, write_tag_array, cache_word_offset);
            end
        end
        @(negedge clk);
        rst            = 1'b0;
        miss_detected  = 1'b0;
        mem_data_valid = 1'b0;
    endtask

    task automatic test_basic;
        run_fill(16'h1236, 4, 0, 0, 1'b0, 1'b0, 0, tc);
        checks++;
        if (tc !== 12) begin
            errors++;
            $display("FAIL basic_tag_cycle: got %0d want 12", tc);
        end
    endtask

    task automatic test_latency1;
        run_fill(16'h0A10, 1, 0, 0, 1'b0, 1'b0, 0, tc);
        checks++;
        if (tc !== LW + 1) begin
            errors++;
            $display("FAIL lat1_busy_cycles: got %0d want %0d", tc, LW + 1);
        end
    endtask

    task automatic test_irregular;
        run_fill(16'h1230, 2, 3, 0, 1'b0, 1'b0, 0, tc);
        checks++;
        if (tc !== 31) begin
            errors++;
            $display("FAIL irregular_tag_cycle: got %0d want 31", tc);
        end
    endtask

    task automatic test_no_wrap;
        run_fill(16'hFFF6, 3, 0, 0, 1'b0, 1'b0, 0, tc);
    endtask

    task automatic test_reset_mid_fill;
        run_fill(16'h2468, 2, 0, 5, 1'b0, 1'b0, 0, tc);
        @(negedge clk);
        rst            = 1'b1;
        miss_detected  = 1'b1;
        mem_data_valid = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (fsm_busy !== 1'b0 || mem_enable !== 1'b0 || mem_addr !== '0
            || write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin
            errors++;
            $display("FAIL midfill_reset: busy=%b en=%b addr=%h wda=%b tag=%b, all should be 0",
                     fsm_busy, mem_enable, mem_addr, write_data_array, write_tag_array);
        end
        @(negedge clk);
        rst           = 1'b0;
        miss_detected = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_data_valid = 1'b1;
            mem_data       = 16'($urandom);
            #1;
            checks++;
            if (fsm_busy !== 1'b0 || mem_enable !== 1'b0 || write_data_array !== 1'b0
                || write_tag_array !== 1'b0 || cache_word_offset !== '0) begin
                errors++;
                $display("FAIL late_valid_%0d: busy=%b en=%b wda=%b tag=%b off=%0d, all should be 0",
                         i, fsm_busy, mem_enable, write_data_array, write_tag_array, cache_word_offset);
            end
            @(negedge clk);
        end
        mem_data_valid = 1'b0;
        run_fill(16'h3000, 3, 1, 0, 1'b0, 1'b0, 0, tc);
    endtask

    task automatic test_back_to_back;
        run_fill(16'h0040, 2, 0, 0, 1'b0, 1'b1, 16'h0080, tc);
        run_fill(16'h0080, 2, 0, 0, 1'b1, 1'b0, 0, tc);
    endtask

    task automatic test_random;
        for (int n = 0; n < 6; n++) begin
            run_fill(int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(1, 6)),
                     int'($urandom_range(0, 2)), 0, 1'b0, 1'b0, 0, tc);
        end
    endtask

    initial begin
        rst            = 1'b1;
        miss_detected  = 1'b0;
        miss_address   = '0;
        mem_data_valid = 1'b0;
        mem_data       = '0;
        test_reset();
        test_basic();
        test_latency1();
        test_irregular();
        test_no_wrap();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: byte-address width of miss_address and mem_addr.
REQ-002 Parameter LINE_WORDS, default 8: 16-bit words per cache line; power of two, 2..16.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 miss_detected  input  1  cache miss request; level, sampled only in IDLE.
REQ-006 miss_address  input  ADDR_WIDTH  byte address of the missing access.
REQ-007 mem_data_valid  input  1  one-cycle strobe; mem_data holds the next in-order returned word.
REQ-008 mem_data  input  16  read data from memory.
REQ-009 fsm_busy  output  1  high while a line fill is in progress.
REQ-010 mem_enable  output  1  read request to memory, one word per cycle it is high.
REQ-011 mem_wr  output  1  memory write enable; constant 0, since this block only reads.
REQ-012 mem_addr  output  ADDR_WIDTH  word-aligned byte address of the current request.
REQ-013 write_data_array  output  1  one-cycle strobe writing cache_data into the cache data array.
REQ-014 write_tag_array  output  1  one-cycle strobe writing the tag for the filled line.
REQ-015 cache_word_offset  output  log2(LINE_WORDS)  word index within the line for write_data_array.
REQ-016 cache_data  output  16  data to the cache data array; equals mem_data combinationally.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ISSUE and DRAIN.
REQ-018 IDLE with miss_detected=1 SHALL move to ISSUE at the next edge.
  - Same edge: register base = miss_address with its low log2(LINE_WORDS)+1 bits cleared.
  - Same edge: clear the issue counter and the return counter to 0.
REQ-019 In ISSUE, mem_enable SHALL be 1 and mem_addr SHALL be base + 2*issue_count.
  - issue_count increments every cycle.
  - After LINE_WORDS consecutive cycles the FSM moves to DRAIN.
  - Addresses SHALL never wrap across the line boundary.
REQ-020 In IDLE and DRAIN, mem_enable SHALL be 0 and mem_addr SHALL be 0.
REQ-021 Returned data, in ISSUE or DRAIN with mem_data_valid=1, SHALL be handled the same cycle:
  - write_data_array = 1;
  - cache_word_offset = return_count;
  - return_count increments at the edge.
REQ-022 Returns SHALL be accepted in ISSUE as well as DRAIN: memory is pipelined, latency at least 1 cycle, in-order.
REQ-023 On the return with return_count = LINE_WORDS-1, write_tag_array SHALL pulse 1 in the same cycle, and the FSM SHALL enter IDLE at the next edge.
REQ-024 If the final return arrives while still in ISSUE (not legal for memory latency ≥1), the FSM SHALL still complete the remaining issues before DRAIN, then go to IDLE; write_tag_array SHALL still fire exactly once per fill.
REQ-025 fsm_busy SHALL be 1 in ISSUE and DRAIN and 0 in IDLE.
  - It rises the cycle after miss acceptance.
  - It falls the cycle after write_tag_array.
REQ-026 miss_detected and miss_address changes SHALL be ignored while busy; base stays constant for the whole fill.
REQ-027 mem_data_valid in IDLE SHALL be ignored: no strobes and no counter change.
REQ-028 miss_detected held high continuously SHALL start a new fill on the first IDLE cycle after completion; there is no minimum gap.
REQ-029 Outside a data-return cycle, write_data_array, write_tag_array and cache_word_offset SHALL be 0.
REQ-030 Counters SHALL be log2(LINE_WORDS)+1 bits wide, so that a count of LINE_WORDS is representable without overflow.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE and clear base, issue_count and return_count.
REQ-032 Reset has priority over every other input.
REQ-033 During and after reset, all registered outputs SHALL be 0: fsm_busy, mem_enable, mem_addr.
REQ-034 After reset, all decoded strobes SHALL be 0: write_data_array, write_tag_array, cache_word_offset.
REQ-035 Reset in the middle of a fill SHALL abandon it with no write_tag_array; returns arriving after reset SHALL be ignored.

Verification
REQ-036 Basic fill: miss_address=0x1236, memory latency 4:
  - mem_addr SHALL be 0x1230, 0x1232, ... 0x123E over 8 cycles;
  - 8 write_data_array pulses with offsets 0..7;
  - write_tag_array on the 8th return; fsm_busy low the cycle after.
REQ-037 Latency 1: returns overlap issue; offsets 0..7 in order; exactly one write_tag_array; total busy = 9 cycles.
REQ-038 Irregular returns: insert 3-cycle gaps between valids → DRAIN holds; the fill completes only after the 8th valid; no extra strobes.
REQ-039 miss_detected toggled with miss_address=0xFFFF mid-fill:
  - base SHALL remain 0x1230;
  - at line 0xFFF0, addresses SHALL be 0xFFF0..0xFFFE with no wrap.
REQ-040 Reset applied after 5 returns: next cycle all outputs SHALL be 0; 3 late valids SHALL produce no strobes; a new miss then restarts at offset 0.
REQ-041 Back-to-back: miss_detected held high across two fills (0x0040, then 0x0080) → the second ISSUE begins the cycle after fsm_busy falls.
